// File: rtl/compound_arbiter_pkg.sv
// Shared types for compound_arbiter: the CompoundType payload, the mode enum,
// the arbiter section encoding and the requester-ID type.
package compound_arbiter_pkg;

  localparam int unsigned COORD_W = 16;

  typedef enum logic {
    mode_read  = 1'b0,
    mode_write = 1'b1
  } mode_e;

  typedef struct packed {
    mode_e              mode;
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
  } compound_t;

  typedef enum logic [1:0] {
    section_idle    = 2'd0,
    section_accept  = 2'd1,
    section_forward = 2'd2
  } compound_arbiter_sections_e;

  typedef logic req_id_t;

  localparam compound_t COMPOUND_RESET = '{mode: mode_read, x: '0, y: '0};

endpackage

// File: rtl/compound_arb_pick.sv
// Combinational winner select between two requesters.
// Ports: sync0/sync1 pending flags, mode0/mode1 requester modes,
//        last_grant previous winner, winner_c selected requester.
module compound_arb_pick
  import compound_arbiter_pkg::*;
#(
  parameter bit WRITE_PRIO = 1'b0
) (
  input  logic    sync0,
  input  logic    sync1,
  input  mode_e   mode0,
  input  mode_e   mode1,
  input  req_id_t last_grant,
  output req_id_t winner_c
);

  // Single requester wins outright; on a tie, write mode first (if enabled),
  // otherwise the one that did not win last.
  always_comb begin
    winner_c = req_id_t'(~last_grant);
    if (sync0 && !sync1) begin
      winner_c = req_id_t'(1'b0);
    end else if (sync1 && !sync0) begin
      winner_c = req_id_t'(1'b1);
    end else if (WRITE_PRIO && (mode0 != mode1)) begin
      winner_c = (mode1 == mode_write) ? req_id_t'(1'b1) : req_id_t'(1'b0);
    end
  end

endmodule

// File: rtl/compound_arbiter.sv
// Two-to-one arbiter for a blocking CompoundType channel: picks a requester,
// captures one transaction, forwards it tagged with its source ID, counts it.
// Ports: clk, rst (async active-low); reqN_in/_sync/_notify producer channels;
//        arb_out/_src/_sync/_notify consumer channel; grant_cntN transfer counts.
module compound_arbiter
  import compound_arbiter_pkg::*;
#(
  parameter bit          WRITE_PRIO = 1'b0,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  compound_t        req0_in,
  input  logic             req0_in_sync,
  output logic             req0_in_notify,
  input  compound_t        req1_in,
  input  logic             req1_in_sync,
  output logic             req1_in_notify,
  output compound_t        arb_out,
  output logic             arb_out_src,
  input  logic             arb_out_sync,
  output logic             arb_out_notify,
  output logic [CNT_W-1:0] grant_cnt0,
  output logic [CNT_W-1:0] grant_cnt1
);

  compound_arbiter_sections_e section_q, section_d;
  req_id_t                    sel_q, sel_d;
  req_id_t                    last_grant_q, last_grant_d;
  logic                       req0_notify_q, req0_notify_d;
  logic                       req1_notify_q, req1_notify_d;
  logic                       out_notify_q, out_notify_d;
  compound_t                  arb_out_q, arb_out_d;
  req_id_t                    src_q, src_d;
  logic [CNT_W-1:0]           cnt0_q, cnt0_d;
  logic [CNT_W-1:0]           cnt1_q, cnt1_d;

  req_id_t                    winner_c;
  logic                       sel_sync_c;
  compound_t                  sel_data_c;

  compound_arb_pick #(
    .WRITE_PRIO(WRITE_PRIO)
  ) u_pick (
    .sync0     (req0_in_sync),
    .sync1     (req1_in_sync),
    .mode0     (req0_in.mode),
    .mode1     (req1_in.mode),
    .last_grant(last_grant_q),
    .winner_c  (winner_c)
  );

  assign sel_sync_c = sel_q ? req1_in_sync : req0_in_sync;
  assign sel_data_c = sel_q ? req1_in : req0_in;

  // Next-state and output computation.
  always_comb begin
    section_d     = section_q;
    sel_d         = sel_q;
    last_grant_d  = last_grant_q;
    req0_notify_d = req0_notify_q;
    req1_notify_d = req1_notify_q;
    out_notify_d  = out_notify_q;
    arb_out_d     = arb_out_q;
    src_d         = src_q;
    cnt0_d        = cnt0_q;
    cnt1_d        = cnt1_q;

    case (section_q)
      section_idle: begin
        if (req0_in_sync || req1_in_sync) begin
          sel_d         = winner_c;
          req0_notify_d = (winner_c == req_id_t'(1'b0));
          req1_notify_d = (winner_c == req_id_t'(1'b1));
          section_d     = section_accept;
        end
      end
      section_accept: begin
        req0_notify_d = 1'b0;
        req1_notify_d = 1'b0;
        // A producer that dropped sync here withdrew: no capture, no count.
        if (sel_sync_c) begin
          arb_out_d    = sel_data_c;
          src_d        = sel_q;
          last_grant_d = sel_q;
          out_notify_d = 1'b1;
          section_d    = section_forward;
        end else begin
          section_d = section_idle;
        end
      end
      section_forward: begin
        if (arb_out_sync) begin
          out_notify_d = 1'b0;
          // Counters saturate at all-ones.
          if (sel_q) begin
            if (cnt1_q != '1) cnt1_d = cnt1_q + CNT_W'(1);
          end else begin
            if (cnt0_q != '1) cnt0_d = cnt0_q + CNT_W'(1);
          end
          section_d = section_idle;
        end
      end
      default: begin
        section_d = section_idle;
      end
    endcase
  end

  // State register; last_grant resets to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      section_q     <= section_idle;
      sel_q         <= req_id_t'(1'b0);
      last_grant_q  <= req_id_t'(1'b1);
      req0_notify_q <= 1'b0;
      req1_notify_q <= 1'b0;
      out_notify_q  <= 1'b0;
      arb_out_q     <= COMPOUND_RESET;
      src_q         <= req_id_t'(1'b0);
      cnt0_q        <= '0;
      cnt1_q        <= '0;
    end else begin
      section_q     <= section_d;
      sel_q         <= sel_d;
      last_grant_q  <= last_grant_d;
      req0_notify_q <= req0_notify_d;
      req1_notify_q <= req1_notify_d;
      out_notify_q  <= out_notify_d;
      arb_out_q     <= arb_out_d;
      src_q         <= src_d;
      cnt0_q        <= cnt0_d;
      cnt1_q        <= cnt1_d;
    end
  end

  assign req0_in_notify = req0_notify_q;
  assign req1_in_notify = req1_notify_q;
  assign arb_out_notify = out_notify_q;
  assign arb_out        = arb_out_q;
  assign arb_out_src    = src_q;
  assign grant_cnt0     = cnt0_q;
  assign grant_cnt1     = cnt1_q;

endmodule

// File: tb/tb_compound_arbiter.sv
// Bench for compound_arbiter: two instances (round-robin with CNT_W=2, and
// write-priority with CNT_W=16) share one stimulus stream and are each
// compared every cycle against a transaction-level reference model.
module tb_compound_arbiter;
  import compound_arbiter_pkg::*;

  logic      clk;
  logic      rst;
  compound_t r0, r1;
  logic      s0, s1, os;

  logic        o_n0[2], o_n1[2], o_on[2], o_src[2];
  compound_t   o_out[2];
  logic [31:0] o_c0[2], o_c1[2];
  logic [1:0]  rr_c0, rr_c1;
  logic [15:0] wp_c0, wp_c1;

  assign o_c0[0] = 32'(rr_c0);
  assign o_c1[0] = 32'(rr_c1);
  assign o_c0[1] = 32'(wp_c0);
  assign o_c1[1] = 32'(wp_c1);

  compound_arbiter #(.WRITE_PRIO(1'b0), .CNT_W(2)) u_rr (
    .clk(clk), .rst(rst),
    .req0_in(r0), .req0_in_sync(s0), .req0_in_notify(o_n0[0]),
    .req1_in(r1), .req1_in_sync(s1), .req1_in_notify(o_n1[0]),
    .arb_out(o_out[0]), .arb_out_src(o_src[0]), .arb_out_sync(os),
    .arb_out_notify(o_on[0]), .grant_cnt0(rr_c0), .grant_cnt1(rr_c1)
  );

  compound_arbiter #(.WRITE_PRIO(1'b1), .CNT_W(16)) u_wp (
    .clk(clk), .rst(rst),
    .req0_in(r0), .req0_in_sync(s0), .req0_in_notify(o_n0[1]),
    .req1_in(r1), .req1_in_sync(s1), .req1_in_notify(o_n1[1]),
    .arb_out(o_out[1]), .arb_out_src(o_src[1]), .arb_out_sync(os),
    .arb_out_notify(o_on[1]), .grant_cnt0(wp_c0), .grant_cnt1(wp_c1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: phase 0 waiting, 1 offering to sel, 2 presenting output.
  int        phase[2];
  int        sel[2];
  int        last[2];
  compound_t mout[2];
  int        msrc[2];
  int        mcnt[2][2];
  int        cmax[2] = '{3, 65535};
  bit        wp[2]   = '{1'b0, 1'b1};

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      phase[k] = 0; sel[k] = 0; last[k] = 1;
      mout[k] = '{mode: mode_read, x: '0, y: '0};
      msrc[k] = 0; mcnt[k][0] = 0; mcnt[k][1] = 0;
    end
  endtask

  task automatic model_step(input int k);
    int w;
    case (phase[k])
      0: if (s0 || s1) begin
        if (s0 && !s1) w = 0;
        else if (s1 && !s0) w = 1;
        else if (wp[k] && (r0.mode != r1.mode)) w = (r1.mode == mode_write) ? 1 : 0;
        else w = 1 - last[k];
        sel[k] = w; phase[k] = 1;
      end
      1: if ((sel[k] == 1) ? s1 : s0) begin
        mout[k] = (sel[k] == 1) ? r1 : r0;
        msrc[k] = sel[k]; last[k] = sel[k]; phase[k] = 2;
      end else phase[k] = 0;
      default: if (os) begin
        if (mcnt[k][sel[k]] < cmax[k]) mcnt[k][sel[k]]++;
        phase[k] = 0;
      end
    endcase
  endtask

  task automatic check_all(input string ph);
    for (int k = 0; k < 2; k++) begin
      check($sformatf("%s/u%0d/n0", ph, k), 64'(o_n0[k]), 64'(phase[k] == 1 && sel[k] == 0));
      check($sformatf("%s/u%0d/n1", ph, k), 64'(o_n1[k]), 64'(phase[k] == 1 && sel[k] == 1));
      check($sformatf("%s/u%0d/on", ph, k), 64'(o_on[k]), 64'(phase[k] == 2));
      check($sformatf("%s/u%0d/out", ph, k), 64'(o_out[k]), 64'(mout[k]));
      check($sformatf("%s/u%0d/src", ph, k), 64'(o_src[k]), 64'(msrc[k]));
      check($sformatf("%s/u%0d/c0", ph, k), 64'(o_c0[k]), 64'(mcnt[k][0]));
      check($sformatf("%s/u%0d/c1", ph, k), 64'(o_c1[k]), 64'(mcnt[k][1]));
    end
  endtask

  task automatic tick(input string ph);
    model_step(0);
    model_step(1);
    @(posedge clk);
    #1;
    check_all(ph);
  endtask

  task automatic apply_reset(input string ph);
    rst = 1'b0;
    #1;
    model_reset();
    check_all({ph, "/rst"});
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_all({ph, "/release"});
  endtask

  function automatic compound_t rand_data();
    compound_t d;
    d.mode = mode_e'($urandom_range(0, 1));
    d.x    = 16'($urandom);
    d.y    = 16'($urandom);
    return d;
  endfunction

  initial begin
    rst = 1'b0; s0 = 1'b0; s1 = 1'b0; os = 1'b0;
    r0 = '{mode: mode_read, x: '0, y: '0};
    r1 = r0;
    apply_reset("init");

    // Single request from requester 0.
    r0 = '{mode: mode_write, x: 16'd5, y: 16'd1}; s0 = 1'b1; os = 1'b1;
    tick("single_a");
    check("single_notify0", 64'(o_n0[0]), 64'd1);
    tick("single_b");
    check("single_out", 64'(o_out[0]), 64'({mode_write, 16'd5, 16'd1}));
    check("single_src", 64'(o_src[0]), 64'd0);
    s0 = 1'b0;
    tick("single_c");
    check("single_on_drop", 64'(o_on[0]), 64'd0);
    check("single_cnt0_rr", 64'(o_c0[0]), 64'd1);
    check("single_cnt0_wp", 64'(o_c0[1]), 64'd1);

    // Round-robin on ties.
    apply_reset("rr");
    r0 = '{mode: mode_read, x: 16'd10, y: 16'd0};
    r1 = '{mode: mode_read, x: 16'd20, y: 16'd0};
    s0 = 1'b1; s1 = 1'b1; os = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick("rr_a");
      tick("rr_b");
      check($sformatf("rr_src%0d_rr", i), 64'(o_src[0]), 64'(i % 2));
      check($sformatf("rr_src%0d_wp", i), 64'(o_src[1]), 64'(i % 2));
      tick("rr_c");
    end
    s0 = 1'b0; s1 = 1'b0;
    check("rr_cnt0", 64'(o_c0[0]), 64'd2);
    check("rr_cnt1", 64'(o_c1[0]), 64'd2);

    // Write priority.
    apply_reset("wp");
    r0 = '{mode: mode_read, x: 16'd1, y: 16'd0};
    r1 = '{mode: mode_write, x: 16'd2, y: 16'd0};
    s0 = 1'b1; s1 = 1'b1; os = 1'b1;
    tick("wp_a");
    tick("wp_b");
    check("wp_first_src", 64'(o_src[1]), 64'd1);
    check("wp_first_x", 64'(o_out[1].x), 64'd2);
    s1 = 1'b0;
    tick("wp_c");
    tick("wp_d");
    tick("wp_e");
    check("wp_second_src", 64'(o_src[1]), 64'd0);
    check("wp_second_x", 64'(o_out[1].x), 64'd1);
    s0 = 1'b0;
    tick("wp_f");

    // Backpressure in the forward section.
    apply_reset("bp");
    r0 = '{mode: mode_write, x: 16'd7, y: 16'd9}; s0 = 1'b1; os = 1'b0;
    tick("bp_a");
    tick("bp_b");
    s0 = 1'b0; r1 = rand_data(); s1 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick("bp_hold");
      check("bp_no_notify1", 64'(o_n1[0]), 64'd0);
      check("bp_on_held", 64'(o_on[0]), 64'd1);
      check("bp_out_held", 64'(o_out[0]), 64'({mode_write, 16'd7, 16'd9}));
    end
    os = 1'b1;
    tick("bp_done");
    check("bp_on_drop", 64'(o_on[0]), 64'd0);
    check("bp_cnt0", 64'(o_c0[0]), 64'd1);
    s1 = 1'b0; os = 1'b0;

    // Withdrawal during accept.
    apply_reset("wd");
    r1 = rand_data(); s1 = 1'b1;
    tick("wd_a");
    check("wd_notify1", 64'(o_n1[0]), 64'd1);
    s1 = 1'b0;
    tick("wd_b");
    check("wd_notify1_drop", 64'(o_n1[0]), 64'd0);
    check("wd_no_out", 64'(o_on[0]), 64'd0);
    check("wd_cnt1", 64'(o_c1[0]), 64'd0);
    r0.mode = mode_read; r1.mode = mode_read; s0 = 1'b1; s1 = 1'b1;
    tick("wd_c");
    check("wd_tie_req0", 64'(o_n0[0]), 64'd1);
    s0 = 1'b0; s1 = 1'b0;
    tick("wd_d");

    // Reset while forwarding.
    apply_reset("mr");
    s0 = 1'b1; os = 1'b0;
    tick("mr_a");
    tick("mr_b");
    check("mr_forwarding", 64'(o_on[0]), 64'd1);
    apply_reset("mr");
    check("mr_on_cleared", 64'(o_on[0]), 64'd0);
    check("mr_out_cleared", 64'(o_out[0]), 64'd0);
    s0 = 1'b0;

    // Counter saturation.
    apply_reset("sat");
    s0 = 1'b1; os = 1'b1;
    for (int i = 0; i < 15; i++) tick("sat");
    check("sat_cnt0_rr", 64'(o_c0[0]), 64'd3);
    check("sat_cnt0_wp", 64'(o_c0[1]), 64'd5);
    s0 = 1'b0;

    // Random traffic against the model.
    apply_reset("rnd");
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) r0 = rand_data();
      if ($urandom_range(0, 3) == 0) r1 = rand_data();
      s0 = ($urandom_range(0, 2) != 0);
      s1 = ($urandom_range(0, 2) != 0);
      os = ($urandom_range(0, 1) != 0);
      if ($urandom_range(0, 99) == 0) apply_reset("rnd");
      tick("rnd");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
